id_ex_ctrl_reg: RTL and testbench
=================================

# id_ex_ctrl_reg

Decode-and-register stage that feeds the execute stage of the RV32I pipeline. Takes a raw 32-bit instruction from IF/ID, produces the `{funct7, funct3}` field, the 2-bit ALU op class and the datapath control bits, and holds them in the ID/EX pipeline register. Supports a valid/ready handshake on both sides, hazard-unit stall bubbles and branch flush. It is the producer side of the `funct`/`ALUop` interface consumed by the ALU control decoder.

## Interface
- No parameters; data width fixed at 32.
- `clk_i` in 1: clock, rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `instr_i` in 32: instruction from IF/ID.
- `valid_i` in 1: `instr_i` valid.
- `ready_o` out 1: stage accepts `instr_i` this cycle.
- `stall_i` in 1: hazard unit requests a bubble (load-use).
- `flush_i` in 1: discard the registered and incoming instruction.
- `ready_i` in 1: execute stage accepts outputs.
- `valid_o` out 1: outputs hold a real instruction.
- `funct_o` out 10: `{funct7, funct3}`.
- `aluop_o` out 2: 00 NOP, 01 load/store, 10 I-type ALU, 11 R-type.
- `rd_o`, `rs1_o`, `rs2_o` out 5 each: register indices.
- `imm_o` out 32: sign-extended immediate.
- `reg_write_o`, `mem_read_o`, `mem_write_o`, `mem_to_reg_o`, `alu_src_o` out 1 each: datapath controls.
- `illegal_o` out 1: present only with `ID_EX_ILLEGAL_TRAP_EN`.

## Operation
Opcode decode, from `instr_i[6:0]`:
- **0110011 (R):** aluop 11, reg_write 1, alu_src 0.
- **0010011 (I):** aluop 10, reg_write 1, alu_src 1.
- **0000011 (load):** aluop 01, reg_write, mem_read, mem_to_reg and alu_src all 1.
- **0100011 (store):** aluop 01, mem_write 1, alu_src 1, reg_write 0.
- **Any other opcode:** decoded as a bubble (aluop 00, all controls 0).

Field extraction:
- `funct_o[2:0]` = `instr[14:12]` for R, I, load and store.
- `funct_o[9:3]` = `instr[31:25]` for R-type only; otherwise 0.
- `rd` = `instr[11:7]`, `rs1` = `instr[19:15]`, `rs2` = `instr[24:20]`.
- For store, `rd_o` = 0. For I/load, `rs2_o` = 0.
- `imm_o`:
  - I/load: `sext(instr[31:20])`.
  - Store: `sext({instr[31:25], instr[11:7]})`.
  - R/other: 0.

Handshake and state (one register stage, state = `valid_o`):
- `ready_o` = `!stall_i && (!valid_o || ready_i)`.
- **Load:** when `valid_i && ready_o && !flush_i`, the register loads the decode result and `valid_o` becomes 1.
- **Stall:** when `stall_i` and (`!valid_o || ready_i`), the register loads a bubble: `valid_o` 0, all controls 0, aluop 00. The upstream instruction is held because `ready_o` = 0.
- **Hold:** when `valid_o && !ready_i`, the register holds all outputs unchanged.
- **Drain:** when `!valid_i` and the slot is free, a bubble is loaded.
- **Flush:** `flush_i` has highest priority. The next edge loads a bubble regardless of `ready_i`, `stall_i` or `valid_i`. An incoming instruction offered that cycle is consumed and dropped (`ready_o` is still reported as computed).
- A bubble always has all controls, aluop, funct, rd, rs1, rs2 and imm equal to 0.

## Timing
- Latency is 1 cycle from the accepting edge to `valid_o`.
- Throughput is 1 instruction/cycle while `ready_i` = 1 and `stall_i` = 0.
- `ready_o` is combinational from `stall_i`, `ready_i` and `valid_o`. No other combinational input-to-output paths.
- **Reset:** asserting `rst_n_i` low immediately forces all outputs to 0, including `valid_o`, `aluop_o` = 00 and `illegal_o`. This holds even mid-handshake. `ready_o` = 1 after reset when `stall_i` = 0.
- Stall and flush in the same cycle: flush wins. The result is identical (bubble) except the upstream instruction is consumed.
- Back-pressure (`ready_i` = 0) combined with `stall_i`: hold takes precedence over stall. No bubble is inserted until `ready_i` returns.

## Configuration
- **`ID_EX_ILLEGAL_TRAP_EN` defined:**
  - `illegal_o` port exists.
  - An accepted instruction with an unsupported opcode loads with `valid_o` = 1, `illegal_o` = 1, and controls as a bubble.
  - `illegal_o` clears with the next load or bubble.
- **Undefined:**
  - Port absent.
  - Unsupported opcodes load as a bubble with `valid_o` = 0, i.e. silently dropped.

## Test plan
- **ADD:** `0x002081B3` with `valid_i` = 1, `ready_i` = 1 → next cycle `valid_o` 1, aluop 11, funct 0000000_000, rd 3, rs1 1, rs2 2, reg_write 1, imm 0.
- **SUB then ADDI back-to-back:**
  - `0x407302B3` → funct 0100000_000, aluop 11, rd 5.
  - Following cycle, `0xFFF00093` → aluop 10, funct 0000000_000, imm `0xFFFFFFFF`, alu_src 1, rd 1.
- **LW then SW:**
  - `0x0080A103` → aluop 01, funct3 010, imm 8, mem_read, mem_to_reg and reg_write all 1.
  - `0x0020A623` → aluop 01, imm 12, rs2 2, rd 0, mem_write 1, reg_write 0.
- **Stall:** hold `stall_i` = 1 for 2 cycles with LW presented → `ready_o` 0, 2 bubbles out (`valid_o` 0, aluop 00). LW emerges the cycle after `stall_i` drops.
- **Back-pressure and flush:**
  - `ready_i` = 0 for 3 cycles → outputs frozen.
  - Then `flush_i` pulse → next cycle `valid_o` 0, all fields 0.
- **Reset and illegal opcode:**
  - Assert `rst_n_i` mid-stream → outputs 0 immediately, before any clock edge.
  - After release, opcode `0x7F` → with the macro: `valid_o` 1, `illegal_o` 1. Without it: `valid_o` 0.

Source files
------------

// File: rtl/id_ex_ctrl_reg.sv
// ID/EX decode-and-register stage: RV32I R/I/load/store decode held behind a valid/ready slot.
// Optional feature macro: ID_EX_ILLEGAL_TRAP_EN (adds illegal_o and forwards unsupported opcodes as traps).
module id_ex_ctrl_reg (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [9:0]  funct_o,
  output logic [1:0]  aluop_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [31:0] imm_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        mem_to_reg_o,
`ifdef ID_EX_ILLEGAL_TRAP_EN
  output logic        illegal_o,
`endif
  output logic        alu_src_o
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic [9:0]  funct;
    logic [1:0]  aluop;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  // Decode one instruction; unsupported opcodes come back as an all-zero bubble.
  function automatic ctrl_t decode_instr(input logic [31:0] ins);
    ctrl_t c;
    c = BUBBLE;
    case (ins[6:0])
      OP_R: begin
        c.funct     = {ins[31:25], ins[14:12]};
        c.aluop     = 2'b11;
        c.rd        = ins[11:7];
        c.rs1       = ins[19:15];
        c.rs2       = ins[24:20];
        c.reg_write = 1'b1;
      end
      OP_I: begin
        c.funct     = {7'd0, ins[14:12]};
        c.aluop     = 2'b10;
        c.rd        = ins[11:7];
        c.rs1       = ins[19:15];
        c.imm       = {{20{ins[31]}}, ins[31:20]};
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_LOAD: begin
        c.funct      = {7'd0, ins[14:12]};
        c.aluop      = 2'b01;
        c.rd         = ins[11:7];
        c.rs1        = ins[19:15];
        c.imm        = {{20{ins[31]}}, ins[31:20]};
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
      end
      OP_STORE: begin
        c.funct     = {7'd0, ins[14:12]};
        c.aluop     = 2'b01;
        c.rs1       = ins[19:15];
        c.rs2       = ins[24:20];
        c.imm       = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      default: c = BUBBLE;
    endcase
    return c;
  endfunction

  ctrl_t pipe_r;
  ctrl_t next_pipe_s;
  ctrl_t dec_s;
  logic  valid_r;
  logic  next_valid_s;
  logic  slot_free_s;
  logic  dec_supported_s;
  logic  illegal_r;
  logic  next_illegal_s;

  // Opcode classification and decode of the offered instruction.
  always_comb begin
    dec_s = decode_instr(instr_i);
    case (instr_i[6:0])
      OP_R, OP_I, OP_LOAD, OP_STORE: dec_supported_s = 1'b1;
      default:                       dec_supported_s = 1'b0;
    endcase
  end

  assign slot_free_s = !valid_r || ready_i;
  assign ready_o     = !stall_i && slot_free_s;

  // Next slot contents: flush beats hold, hold beats stall, then load or drain.
  always_comb begin
    next_valid_s   = valid_r;
    next_pipe_s    = pipe_r;
    next_illegal_s = illegal_r;
    if (flush_i) begin
      next_valid_s   = 1'b0;
      next_pipe_s    = BUBBLE;
      next_illegal_s = 1'b0;
    end else if (!slot_free_s) begin
      next_valid_s   = valid_r;
      next_pipe_s    = pipe_r;
      next_illegal_s = illegal_r;
    end else if (stall_i || !valid_i) begin
      next_valid_s   = 1'b0;
      next_pipe_s    = BUBBLE;
      next_illegal_s = 1'b0;
    end else if (dec_supported_s) begin
      next_valid_s   = 1'b1;
      next_pipe_s    = dec_s;
      next_illegal_s = 1'b0;
    end else begin
      next_pipe_s    = BUBBLE;
`ifdef ID_EX_ILLEGAL_TRAP_EN
      next_valid_s   = 1'b1;
      next_illegal_s = 1'b1;
`else
      next_valid_s   = 1'b0;
      next_illegal_s = 1'b0;
`endif
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_r   <= 1'b0;
      pipe_r    <= BUBBLE;
      illegal_r <= 1'b0;
    end else begin
      valid_r   <= next_valid_s;
      pipe_r    <= next_pipe_s;
      illegal_r <= next_illegal_s;
    end
  end

  assign valid_o      = valid_r;
  assign funct_o      = pipe_r.funct;
  assign aluop_o      = pipe_r.aluop;
  assign rd_o         = pipe_r.rd;
  assign rs1_o        = pipe_r.rs1;
  assign rs2_o        = pipe_r.rs2;
  assign imm_o        = pipe_r.imm;
  assign reg_write_o  = pipe_r.reg_write;
  assign mem_read_o   = pipe_r.mem_read;
  assign mem_write_o  = pipe_r.mem_write;
  assign mem_to_reg_o = pipe_r.mem_to_reg;
  assign alu_src_o    = pipe_r.alu_src;

`ifdef ID_EX_ILLEGAL_TRAP_EN
  assign illegal_o = illegal_r;
`else
  // Without the trap option the flag can never be set and has no consumer.
  logic unused_illegal_s;
  assign unused_illegal_s = illegal_r;
`endif

endmodule

// File: tb/tb_id_ex_ctrl_reg.sv
// Self-checking bench for id_ex_ctrl_reg: field-level reference model plus directed literal checks.
module tb_id_ex_ctrl_reg;

  typedef struct packed {
    logic        valid;
    logic [9:0]  funct;
    logic [1:0]  aluop;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        asrc;
    logic        ill;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        valid_i = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ready_i = 1'b1;
  logic        ready_o, valid_o, rw, mr, mw, m2r, asrc, ill;
  logic [9:0]  funct;
  logic [1:0]  aluop;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  int errors = 0;
  int checks = 0;

  out_t exp_q;
  out_t act;
  logic slot_free;

  always #5 clk = ~clk;

  id_ex_ctrl_reg dut (
    .clk_i(clk), .rst_n_i(rst_n), .instr_i(instr), .valid_i(valid_i), .ready_o(ready_o),
    .stall_i(stall), .flush_i(flush), .ready_i(ready_i), .valid_o(valid_o),
    .funct_o(funct), .aluop_o(aluop), .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2), .imm_o(imm),
    .reg_write_o(rw), .mem_read_o(mr), .mem_write_o(mw), .mem_to_reg_o(m2r),
`ifdef ID_EX_ILLEGAL_TRAP_EN
    .illegal_o(ill),
`endif
    .alu_src_o(asrc)
  );

`ifndef ID_EX_ILLEGAL_TRAP_EN
  assign ill = 1'b0;
`endif

  assign act = '{valid_o, funct, aluop, rd, rs1, rs2, imm, rw, mr, mw, m2r, asrc, ill};

  // Reference decode: what the stage must present after accepting ins.
  function automatic out_t model_decode(input logic [31:0] ins);
    out_t o;
    logic is_r, is_i, is_ld, is_st, known;
    logic [11:0] s_imm;
    o = '0;
    is_r  = (ins[6:0] == 7'h33);
    is_i  = (ins[6:0] == 7'h13);
    is_ld = (ins[6:0] == 7'h03);
    is_st = (ins[6:0] == 7'h23);
    known = is_r | is_i | is_ld | is_st;
    s_imm = {ins[31:25], ins[11:7]};
    if (known) begin
      o.valid = 1'b1;
      o.funct = is_r ? {ins[31:25], ins[14:12]} : {7'd0, ins[14:12]};
      o.aluop = is_r ? 2'd3 : (is_i ? 2'd2 : 2'd1);
      o.rd    = is_st ? 5'd0 : ins[11:7];
      o.rs1   = ins[19:15];
      o.rs2   = (is_r || is_st) ? ins[24:20] : 5'd0;
      if (is_i || is_ld) o.imm = 32'(signed'(ins[31:20]));
      if (is_st)         o.imm = 32'(signed'(s_imm));
      o.rw   = is_r | is_i | is_ld;
      o.mr   = is_ld;
      o.m2r  = is_ld;
      o.mw   = is_st;
      o.asrc = !is_r;
    end else begin
`ifdef ID_EX_ILLEGAL_TRAP_EN
      o.valid = 1'b1;
      o.ill   = 1'b1;
`else
      o.valid = 1'b0;
`endif
    end
    return o;
  endfunction

  assign slot_free = !exp_q.valid || ready_i;

  // Reference slot state, updated on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                exp_q <= '0;
    else if (flush)            exp_q <= '0;
    else if (!slot_free)       exp_q <= exp_q;
    else if (stall || !valid_i) exp_q <= '0;
    else                       exp_q <= model_decode(instr);
  end

  // Every-cycle comparison against the reference model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (act !== exp_q) begin
      errors++;
      $display("FAIL model_cmp t=%0t act=%h exp=%h", $time, act, exp_q);
    end
    checks++;
    if (ready_o !== (!stall && slot_free)) begin
      errors++;
      $display("FAIL ready_cmp t=%0t act=%b exp=%b", $time, ready_o, !stall && slot_free);
    end
  end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic s, input logic r, input logic f);
    instr = i; valid_i = v; stall = s; ready_i = r; flush = f;
  endtask

  // instr, valid, stall, ready, flush
  logic [35:0] table_v [10] = '{
    {32'h00B50533, 4'b1010}, {32'h0040A283, 4'b1110}, {32'h0040A283, 4'b1100},
    {32'h0040A283, 4'b1010}, {32'hFE552E23, 4'b1000}, {32'hFE552E23, 4'b1111},
    {32'h0000007F, 4'b1010}, {32'h80000013, 4'b1010}, {32'h00000000, 4'b0010},
    {32'h00A12023, 4'b1011}
  };

  initial begin
    drive(32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); step();
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    chk("reset_aluop", {30'd0, aluop}, 32'd0);
    chk("reset_ready", {31'd0, ready_o}, 32'd1);
    @(negedge clk); #2 rst_n = 1'b1;

    drive(32'h002081B3, 1'b1, 1'b0, 1'b1, 1'b0); step();
    chk("add_valid", {31'd0, valid_o}, 32'd1);
    chk("add_aluop", {30'd0, aluop}, 32'd3);
    chk("add_regs", {17'd0, rd, rs1, rs2}, {17'd0, 5'd3, 5'd1, 5'd2});
    chk("add_funct_imm", {22'd0, funct} | imm, 32'd0);
    chk("add_rw", {31'd0, rw}, 32'd1);

    drive(32'h407302B3, 1'b1, 1'b0, 1'b1, 1'b0); step();
    chk("sub_funct", {22'd0, funct}, 32'h100);
    chk("sub_rd", {27'd0, rd}, 32'd5);
    drive(32'hFFF00093, 1'b1, 1'b0, 1'b1, 1'b0); step();
    chk("addi_aluop", {30'd0, aluop}, 32'd2);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_src_rd", {26'd0, asrc, rd}, {26'd0, 1'b1, 5'd1});
    chk("addi_funct", {22'd0, funct}, 32'd0);

    drive(32'h0080A103, 1'b1, 1'b0, 1'b1, 1'b0); step();
    chk("lw_aluop_f3", {27'd0, aluop, funct[2:0]}, {27'd0, 2'd1, 3'b010});
    chk("lw_imm", imm, 32'd8);
    chk("lw_ctrl", {29'd0, mr, m2r, rw}, 32'd7);
    drive(32'h0020A623, 1'b1, 1'b0, 1'b1, 1'b0); step();
    chk("sw_imm", imm, 32'd12);
    chk("sw_rs2_rd", {22'd0, rs2, rd}, {22'd0, 5'd2, 5'd0});
    chk("sw_ctrl", {30'd0, mw, rw}, 32'd2);

    drive(32'h0080A103, 1'b1, 1'b1, 1'b1, 1'b0); #1;
    chk("stall_ready", {31'd0, ready_o}, 32'd0);
    step();
    chk("stall_bubble1", {29'd0, valid_o, aluop}, 32'd0);
    step();
    chk("stall_bubble2", {29'd0, valid_o, aluop}, 32'd0);
    stall = 1'b0; step();
    chk("stall_lw_out", {29'd0, valid_o, aluop}, {29'd0, 1'b1, 2'd1});

    drive(32'h002081B3, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_frozen", imm, 32'd8);
      chk("bp_ready", {31'd0, ready_o}, 32'd0);
    end
    flush = 1'b1; step();
    chk("flush_valid", {31'd0, valid_o}, 32'd0);
    chk("flush_fields", {22'd0, funct} | imm | {17'd0, rd, rs1, rs2} | {30'd0, aluop}, 32'd0);

    for (int k = 0; k < 10; k++) begin
      drive(table_v[k][35:4], table_v[k][3], table_v[k][2], table_v[k][1], table_v[k][0]);
      step();
    end

    drive(32'h002081B3, 1'b1, 1'b0, 1'b1, 1'b0); step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", act, 32'd0);
    chk("async_reset_ready", {31'd0, ready_o}, 32'd1);
    @(negedge clk); #2 rst_n = 1'b1;

    drive(32'h0000007F, 1'b1, 1'b0, 1'b1, 1'b0); step();
`ifdef ID_EX_ILLEGAL_TRAP_EN
    chk("illegal_flags", {30'd0, valid_o, ill}, 32'd3);
    chk("illegal_aluop", {30'd0, aluop}, 32'd0);
`else
    chk("illegal_dropped", {31'd0, valid_o}, 32'd0);
`endif
    drive(32'd0, 1'b0, 1'b0, 1'b1, 1'b0); step();
    chk("drain_bubble", {31'd0, valid_o}, 32'd0);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
